// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: ALU control codes, ALUOp classes,
// funct fields and the issue FSM state.
package alu_pkg;

    // ALU control codes driven on ALUCtrl_o
    localparam logic [2:0] ALUCTRL_AND = 3'b000;
    localparam logic [2:0] ALUCTRL_OR  = 3'b001;
    localparam logic [2:0] ALUCTRL_ADD = 3'b010;
    localparam logic [2:0] ALUCTRL_MUL = 3'b100;
    localparam logic [2:0] ALUCTRL_SUB = 3'b110;

    // ALUOp classes from the main decoder
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // funct7 / funct3 field values
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the issue-side, ALU-side and result-side signals of alu_issue.
// master = the environment (upstream, ALU, downstream); slave = alu_issue.
interface alu_issue_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [1:0]       ALUOp_i;
    logic [9:0]       funct_i;
    logic             ALUSrc_i;
    logic [WIDTH-1:0] rs1data_i;
    logic [WIDTH-1:0] rs2data_i;
    logic [WIDTH-1:0] imm_i;
    logic [4:0]       rd_i;
    logic [WIDTH-1:0] data1_o;
    logic [WIDTH-1:0] data2_o;
    logic [2:0]       ALUCtrl_o;
    logic [WIDTH-1:0] alu_data_i;
    logic [WIDTH-1:0] result_o;
    logic [4:0]       rd_o;
    logic             illegal_o;
    logic             result_valid_o;
    logic             result_ready_i;

    modport master (
        output valid_i, ALUOp_i, funct_i, ALUSrc_i, rs1data_i, rs2data_i, imm_i, rd_i,
               alu_data_i, result_ready_i,
        input  ready_o, data1_o, data2_o, ALUCtrl_o, result_o, rd_o, illegal_o,
               result_valid_o
    );

    modport slave (
        input  valid_i, ALUOp_i, funct_i, ALUSrc_i, rs1data_i, rs2data_i, imm_i, rd_i,
               alu_data_i, result_ready_i,
        output ready_o, data1_o, data2_o, ALUCtrl_o, result_o, rd_o, illegal_o,
               result_valid_o
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode from {ALUOp, funct7, funct3}; undecodable
// combinations fall back to code 000 and raise illegal_o.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp_i,
    input  logic [9:0] funct_i,
    output logic [2:0] ALUCtrl_o,
    output logic       illegal_o
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        ALUCtrl_o = ALUCTRL_AND;
        illegal_o = 1'b0;
        case (ALUOp_i)
            ALUOP_MEM:    ALUCtrl_o = ALUCTRL_ADD;
            ALUOP_BRANCH: ALUCtrl_o = ALUCTRL_SUB;
            ALUOP_ITYPE: begin
                if (funct_i[2:0] == F3_ADD) begin
                    ALUCtrl_o = ALUCTRL_ADD;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            ALUOP_RTYPE: begin
                case (funct_i)
                    {F7_BASE,   F3_ADD}: ALUCtrl_o = ALUCTRL_ADD;
                    {F7_ALT,    F3_ADD}: ALUCtrl_o = ALUCTRL_SUB;
                    {F7_MULDIV, F3_ADD}: ALUCtrl_o = ALUCTRL_MUL;
                    {F7_BASE,   F3_AND}: ALUCtrl_o = ALUCTRL_AND;
                    {F7_BASE,   F3_OR }: ALUCtrl_o = ALUCTRL_OR;
                    default:             illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of a registered ALU: accepts one op, presents operands,
// captures the ALU result one cycle later and holds it until consumed.
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    alu_issue_if.slave  bus
);

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] data1_q,   data1_d;
    logic [WIDTH-1:0] data2_q,   data2_d;
    logic [2:0]       ctrl_q,    ctrl_d;
    logic [4:0]       rd_q,      rd_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] result_q,  result_d;

    logic [2:0]       dec_ctrl;
    logic             dec_illegal;
    logic             ready;
    logic             accept;

    alu_ctrl_decode u_decode (
        .ALUOp_i   (bus.ALUOp_i),
        .funct_i   (bus.funct_i),
        .ALUCtrl_o (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    // ready is gated by rst_i so it is low for the whole reset pulse
    assign ready  = (state_q == IDLE) && !rst_i;
    assign accept = bus.valid_i && ready;

    always_comb begin
        state_d   = state_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = EXEC;
                    data1_d   = bus.rs1data_i;
                    data2_d   = bus.ALUSrc_i ? bus.imm_i : bus.rs2data_i;
                    ctrl_d    = dec_ctrl;
                    rd_d      = bus.rd_i;
                    illegal_d = dec_illegal;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                state_d  = DONE;
                result_d = bus.alu_data_i;
            end
            DONE: begin
                if (bus.result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its _d input regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            data1_q   <= '0;
            data2_q   <= '0;
            ctrl_q    <= ALUCTRL_AND;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
            result_q  <= result_d;
        end
    end

    assign bus.ready_o        = ready;
    assign bus.data1_o        = data1_q;
    assign bus.data2_o        = data2_q;
    assign bus.ALUCtrl_o      = ctrl_q;
    assign bus.result_o       = result_q;
    assign bus.rd_o           = rd_q;
    assign bus.illegal_o      = illegal_q;
    assign bus.result_valid_o = (state_q == DONE);

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed ops, a registered ALU stand-in,
// and a transaction-level model compared against the DUT every cycle.
module tb_alu_issue;

    localparam int WIDTH = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    alu_issue_if #(.WIDTH(WIDTH)) bus ();

    alu_issue #(.WIDTH(WIDTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [1:0]       aluop;
        logic [9:0]       funct;
        logic             alusrc;
        logic [WIDTH-1:0] rs1;
        logic [WIDTH-1:0] rs2;
        logic [WIDTH-1:0] imm;
        logic [4:0]       rd;
    } op_t;

    typedef struct {
        logic [2:0]       ctrl;
        logic             ill;
        logic [WIDTH-1:0] op2;
        logic [WIDTH-1:0] res;
    } exp_t;

    function automatic op_t mk(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
                               input logic alusrc, input logic [WIDTH-1:0] rs1,
                               input logic [WIDTH-1:0] rs2, input logic [WIDTH-1:0] imm,
                               input logic [4:0] rd);
        op_t o;
        o.aluop = aluop; o.funct = {f7, f3}; o.alusrc = alusrc;
        o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.rd = rd;
        return o;
    endfunction

    // What the op must do, straight from the decode table and operand rules
    function automatic exp_t spec_expect(input op_t o);
        exp_t e;
        logic [WIDTH-1:0] a;
        a     = o.rs1;
        e.op2 = o.alusrc ? o.imm : o.rs2;
        e.ill = 1'b0;
        e.ctrl = 3'b000;
        e.res  = a & e.op2;
        if (o.aluop == 2'b00) begin
            e.ctrl = 3'b010; e.res = a + e.op2;
        end else if (o.aluop == 2'b01) begin
            e.ctrl = 3'b110; e.res = a - e.op2;
        end else if (o.aluop == 2'b11) begin
            if (o.funct[2:0] == 3'b000) begin
                e.ctrl = 3'b010; e.res = a + e.op2;
            end else e.ill = 1'b1;
        end else begin
            if      (o.funct == 10'b0000000_000) begin e.ctrl = 3'b010; e.res = a + e.op2; end
            else if (o.funct == 10'b0100000_000) begin e.ctrl = 3'b110; e.res = a - e.op2; end
            else if (o.funct == 10'b0000001_000) begin e.ctrl = 3'b100; e.res = a * e.op2; end
            else if (o.funct == 10'b0000000_111) begin e.ctrl = 3'b000; e.res = a & e.op2; end
            else if (o.funct == 10'b0000000_110) begin e.ctrl = 3'b001; e.res = a | e.op2; end
            else e.ill = 1'b1;
        end
        return e;
    endfunction

    // Registered ALU stand-in: result visible one cycle after operands
    function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] c, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (c)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b100:  return a * b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk_i) bus.alu_data_i <= alu_fn(bus.ALUCtrl_o, bus.data1_o, bus.data2_o);

    // Transaction model: an op accepted at edge N shows its result after edge
    // N+2 and is retired at the first later edge that sees result_ready_i.
    logic             m_busy, m_valid;
    int               edge_n = 0;
    int               acc_edge = 0;
    logic [WIDTH-1:0] m_d1, m_d2, m_res;
    logic [2:0]       m_ctrl;
    logic [4:0]       m_rd;
    logic             m_ill;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_busy = 1'b0; m_valid = 1'b0;
            m_d1 = '0; m_d2 = '0; m_res = '0; m_ctrl = 3'b000; m_rd = '0; m_ill = 1'b0;
        end else begin
            edge_n++;
            if (m_busy) begin
                if (m_valid) begin
                    if (bus.result_ready_i) begin
                        m_busy = 1'b0; m_valid = 1'b0;
                    end
                end else if (edge_n == acc_edge + 2) begin
                    m_valid = 1'b1;
                end
            end else if (bus.valid_i) begin
                op_t  o;
                exp_t e;
                o = mk(bus.ALUOp_i, bus.funct_i[9:3], bus.funct_i[2:0], bus.ALUSrc_i,
                       bus.rs1data_i, bus.rs2data_i, bus.imm_i, bus.rd_i);
                e = spec_expect(o);
                m_d1 = o.rs1; m_d2 = e.op2; m_ctrl = e.ctrl;
                m_res = e.res; m_rd = o.rd; m_ill = e.ill;
                m_busy = 1'b1; acc_edge = edge_n;
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_i) begin
            check("rst_operands", {bus.data1_o, bus.data2_o}, '0);
            check("rst_result", {bus.result_o, bus.rd_o, bus.illegal_o}, '0);
            check("rst_ctrl_flags", {bus.ALUCtrl_o, bus.result_valid_o, bus.ready_o}, '0);
        end else begin
            check("ready", bus.ready_o, !m_busy);
            check("result_valid", bus.result_valid_o, m_valid);
            check("operands", {bus.ALUCtrl_o, bus.data1_o, bus.data2_o}, {m_ctrl, m_d1, m_d2});
            if (m_valid) check("result", {bus.result_o, bus.rd_o, bus.illegal_o}, {m_res, m_rd, m_ill});
        end
    end

    task automatic drive(input op_t o);
        bus.valid_i   = 1'b1;
        bus.ALUOp_i   = o.aluop;
        bus.funct_i   = o.funct;
        bus.ALUSrc_i  = o.alusrc;
        bus.rs1data_i = o.rs1;
        bus.rs2data_i = o.rs2;
        bus.imm_i     = o.imm;
        bus.rd_i      = o.rd;
    endtask

    task automatic scramble();
        bus.ALUOp_i   = 2'($urandom);
        bus.funct_i   = 10'($urandom);
        bus.ALUSrc_i  = 1'($urandom);
        bus.rs1data_i = $urandom;
        bus.rs2data_i = $urandom;
        bus.imm_i     = $urandom;
        bus.rd_i      = 5'($urandom);
    endtask

    // Called just after a falling edge with the DUT idle; returns 1 ns after
    // the accepting edge with the inputs already scrambled.
    task automatic issue(input op_t o);
        drive(o);
        @(posedge clk_i);
        #1;
        bus.valid_i = 1'b0;
        scramble();
    endtask

    // Counts falling edges after the accepting edge until result_valid_o.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_i);
            if (bus.result_valid_o) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("result_timeout", bus.result_valid_o, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    op_t tbl[8];
    int  lat;

    initial begin
        bus.valid_i = 1'b0;
        bus.result_ready_i = 1'b1;
        scramble();

        repeat (3) @(negedge clk_i);
        check("ready_in_reset", bus.ready_o, 1'b0);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_reset", bus.ready_o, 1'b1);

        // R-type add 5 + 7
        issue(mk(2'b10, 7'b0000000, 3'b000, 1'b0, 32'd5, 32'd7, 32'd99, 5'd3));
        check("add_ctrl", bus.ALUCtrl_o, 3'b010);
        wait_result(lat);
        check("add_latency", lat, 3);
        check("add_result", {bus.result_o, bus.rd_o, bus.illegal_o}, {32'd12, 5'd3, 1'b0});
        @(negedge clk_i);
        check("add_back_idle", bus.ready_o, 1'b1);

        // mul 6 * 7 with downstream stalling; a second request must be ignored
        bus.result_ready_i = 1'b0;
        issue(mk(2'b10, 7'b0000001, 3'b000, 1'b0, 32'd6, 32'd7, 32'd0, 5'd9));
        check("mul_ctrl", bus.ALUCtrl_o, 3'b100);
        wait_result(lat);
        check("mul_latency", lat, 3);
        drive(mk(2'b10, 7'b0000000, 3'b000, 1'b0, 32'd100, 32'd1, 32'd0, 5'd1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("mul_hold", {bus.result_o, bus.rd_o, bus.ready_o, bus.result_valid_o},
                  {32'd42, 5'd9, 1'b0, 1'b1});
        end
        bus.valid_i = 1'b0;
        bus.result_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("mul_release", {bus.ready_o, bus.result_valid_o}, {1'b1, 1'b0});
        @(negedge clk_i);

        // I-type add wraps to zero; funct7 is don't-care, imm replaces rs2
        issue(mk(2'b11, 7'b1010101, 3'b000, 1'b1, 32'hFFFF_FFFF, 32'h99, 32'd1, 5'd4));
        check("itype_op2", bus.data2_o, 32'd1);
        wait_result(lat);
        check("itype_result", bus.result_o, 32'h0000_0000);
        @(negedge clk_i);

        // Undecodable R-type: ctrl 000, flagged, ALU (and) output still carried
        issue(mk(2'b10, 7'b1111111, 3'b010, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd17));
        check("illegal_ctrl", bus.ALUCtrl_o, 3'b000);
        wait_result(lat);
        check("illegal_result", {bus.illegal_o, bus.rd_o, bus.result_o}, {1'b1, 5'd17, 32'h0000_F000});
        @(negedge clk_i);

        // Remaining decode rows and corner values, checked by the model
        tbl[0] = mk(2'b10, 7'b0100000, 3'b000, 1'b0, 32'd20, 32'd30, 32'd0, 5'd5);
        tbl[1] = mk(2'b10, 7'b0000000, 3'b111, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 5'd6);
        tbl[2] = mk(2'b10, 7'b0000000, 3'b110, 1'b0, 32'hA000_0005, 32'h0500_0030, 32'd0, 5'd7);
        tbl[3] = mk(2'b00, 7'b1111111, 3'b101, 1'b1, 32'h0000_1000, 32'd0, 32'h24, 5'd8);
        tbl[4] = mk(2'b01, 7'b0000001, 3'b111, 1'b0, 32'd5, 32'd5, 32'd7, 5'd10);
        tbl[5] = mk(2'b11, 7'b0000000, 3'b100, 1'b1, 32'd3, 32'd4, 32'd5, 5'd11);
        tbl[6] = mk(2'b10, 7'b0100000, 3'b111, 1'b0, 32'd3, 32'd6, 32'd0, 5'd12);
        tbl[7] = mk(2'b10, 7'b0000001, 3'b000, 1'b0, 32'h0001_0000, 32'h0001_0003, 32'd0, 5'd31);
        foreach (tbl[i]) begin
            issue(tbl[i]);
            wait_result(lat);
            check("table_latency", lat, 3);
            @(negedge clk_i);
        end

        // valid_i held high: one op per four cycles
        drive(mk(2'b10, 7'b0000000, 3'b110, 1'b0, 32'd1, 32'd2, 32'd0, 5'd13));
        repeat (12) @(negedge clk_i);
        bus.valid_i = 1'b0;
        repeat (4) @(negedge clk_i);

        // Reset pulse while the op sits in CAPT: no result, then recover
        issue(mk(2'b10, 7'b0100000, 3'b000, 1'b0, 32'd100, 32'd1, 32'd0, 5'd20));
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("capt_rst_outs", {bus.data1_o, bus.data2_o, bus.result_o, bus.rd_o, bus.illegal_o,
                                bus.ALUCtrl_o, bus.result_valid_o, bus.ready_o}, '0);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("no_stale_valid", {bus.result_valid_o, bus.ready_o}, {1'b0, 1'b1});
        end

        issue(mk(2'b10, 7'b0100000, 3'b000, 1'b0, 32'd9, 32'd4, 32'd0, 5'd2));
        check("sub_ctrl", bus.ALUCtrl_o, 3'b110);
        wait_result(lat);
        check("sub_latency", lat, 3);
        check("sub_result", {bus.result_o, bus.rd_o}, {32'd5, 5'd2});
        repeat (2) @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
